mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 131 +++++++++++++
 tb/tb_mult_div_unit.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: 32-iteration shift-add multiply and restoring
// divide with a fixed 34-cycle latency from start edge to done pulse.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        is_div_q;
  logic        qneg_q;
  logic        rneg_q;
  logic        dz_q;
  logic [31:0] a_q;
  logic [31:0] mb_q;
  logic [63:0] acc_q;
  logic [63:0] acc_d;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic        sgn;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [32:0] madd;
  logic [32:0] trial;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  assign sgn = ~op[0];
  assign ma  = (sgn && a[31]) ? -a : a;
  assign mb  = (sgn && b[31]) ? -b : b;

  // multiplier sits in acc low half; divisor or multiplicand lives in mb_q
  assign madd  = {1'b0, acc_q[63:32]}
               + (acc_q[0] ? {1'b0, mb_q} : 33'd0);
  assign trial = acc_q[63:31] - {1'b0, mb_q};

  always_comb begin
    acc_d = {madd, acc_q[31:1]};
    if (is_div_q) begin
      if (trial[32]) acc_d = {acc_q[62:0], 1'b0};
      else acc_d = {trial[31:0], acc_q[30:0], 1'b1};
    end
  end

  assign prod = qneg_q ? -acc_q : acc_q;
  assign quo  = qneg_q ? -acc_q[31:0] : acc_q[31:0];
  assign rem  = rneg_q ? -acc_q[63:32] : acc_q[63:32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      a_q      <= 32'd0;
      mb_q     <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            cnt_q    <= 5'd31;
            is_div_q <= op[1];
            qneg_q   <= sgn & (a[31] ^ b[31]);
            rneg_q   <= sgn & a[31] & op[1];
            dz_q     <= op[1] & (b == 32'd0);
            a_q      <= a;
            mb_q     <= mb;
            acc_q    <= {32'd0, ma};
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_q <= FINISH;
        end
        FINISH: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          if (!is_div_q) begin
            hi_q <= prod[63:32];
            lo_q <= prod[31:0];
          end else if (dz_q) begin
            hi_q <= a_q;
            lo_q <= 32'hFFFF_FFFF;
          end else begin
            hi_q <= rem;
            lo_q <= quo;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against an
// arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk = 0;
  int n_fail = 0;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(
    input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int sx, sy, q, r;
    logic [31:0] uq, ur;
    sx = x;
    sy = y;
    case (o)
      2'd0: begin
        p = longint'(sx) * longint'(sy);
        return p;
      end
      2'd1: return {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          return {32'd0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {r, q};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        uq = x / y;
        ur = x % y;
        return {ur, uq};
      end
    endcase
  endfunction

  // drive start for one edge; returns #1 into cycle 1
  task automatic launch(
    input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // advance until done or cycle 40; cyc = cycle index where done seen
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 0 || lo !== 0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h want 0",
               busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_latency;
    logic [31:0] h0, l0;
    int bad_busy;
    h0 = hi;
    l0 = lo;
    bad_busy = 0;
    launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 1; k <= 33; k++) begin
      if (busy !== 1'b1 || done !== 1'b0 || hi !== h0 || lo !== l0)
        bad_busy++;
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (bad_busy != 0) begin
      n_fail++;
      $display("FAIL busy_window: %0d bad cycles in 1..33, want 0",
               bad_busy);
    end
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 ||
        hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL multu_max: done=%b busy=%b hi=%h lo=%h want 1 0 fffffffe 00000001",
               done, busy, hi, lo);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: done=%b at cycle 35 want 0", done);
    end
  endtask

  task automatic test_vectors;
    logic [1:0]  vo[5];
    logic [31:0] va[5];
    logic [31:0] vb[5];
    logic [63:0] ve[5];
    int cyc;
    vo = '{2'd0, 2'd2, 2'd3, 2'd2, 2'd2};
    va = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h64, 32'h8000_0000, 32'hFFFF_FFF9};
    vb = '{32'd5, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    ve = '{{32'hFFFF_FFFF, 32'hFFFF_FFF1},
           {32'hFFFF_FFFF, 32'hFFFF_FFFD},
           {32'h0000_0064, 32'hFFFF_FFFF},
           {32'h0000_0000, 32'h8000_0000},
           {32'hFFFF_FFF9, 32'hFFFF_FFFF}};
    for (int i = 0; i < 5; i++) begin
      launch(vo[i], va[i], vb[i]);
      wait_done(1, cyc);
      n_chk++;
      if (cyc != 34 || {hi, lo} !== ve[i]) begin
        n_fail++;
        $display("FAIL vector%0d: cycle=%0d hi=%h lo=%h want 34 %h %h",
                 i, cyc, hi, lo, ve[i][63:32], ve[i][31:0]);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] x, y;
    logic [63:0] exp;
    int cyc;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'd1;
        2: y = 32'hFFFF_FFFF;
        3: y = y >> $urandom_range(1, 31);
        4: x = 32'h8000_0000;
        default: ;
      endcase
      exp = model(o, x, y);
      launch(o, x, y);
      wait_done(1, cyc);
      n_chk++;
      if (cyc != 34 || {hi, lo} !== exp) begin
        n_fail++;
        $display("FAIL random%0d op=%0d a=%h b=%h: cycle=%0d hi=%h lo=%h want 34 %h %h",
                 i, o, x, y, cyc, hi, lo, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_busy_start;
    logic [63:0] exp;
    int cyc, extra;
    exp = model(2'd0, 32'h1234_5678, 32'hFEDC_BA98);
    launch(2'd0, 32'h1234_5678, 32'hFEDC_BA98);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    op = 2'd1;
    a = 32'd2;
    b = 32'd3;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_done(8, cyc);
    n_chk++;
    if (cyc != 34 || {hi, lo} !== exp) begin
      n_fail++;
      $display("FAIL start_while_busy: cycle=%0d hi=%h lo=%h want 34 %h %h",
               cyc, hi, lo, exp[63:32], exp[31:0]);
    end
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    n_chk++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL no_second_op: %0d busy/done cycles want 0", extra);
    end
  endtask

  task automatic test_midreset;
    int cyc, seen;
    logic [63:0] exp;
    @(negedge clk);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hA5A5_5A5A;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    launch(2'd3, 32'hDEAD_BEEF, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || hi !== 0 || lo !== 0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h want 0",
               busy, done, hi, lo);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    seen = 0;
    reset = 1'b1;
    start = 1'b1;
    op = 2'd3;
    a = 32'd1000;
    b = 32'd33;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_edge_start: busy=%b want 1", busy);
    end
    exp = model(2'd3, 32'd1000, 32'd33);
    cyc = 1;
    while (!done && cyc < 40) begin
      if (hi !== 0 || lo !== 0) seen++;
      @(posedge clk);
      #1;
      cyc++;
    end
    n_chk++;
    if (seen != 0 || cyc != 34 || {hi, lo} !== exp) begin
      n_fail++;
      $display("FAIL after_reset_op: cycle=%0d early=%0d hi=%h lo=%h want 34 0 %h %h",
               cyc, seen, hi, lo, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_mthi;
    int cyc;
    logic [63:0] exp;
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'h1234;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    n_chk++;
    if (hi !== 32'h1234) begin
      n_fail++;
      $display("FAIL mthi: hi=%h want 00001234", hi);
    end
    @(negedge clk);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    n_chk++;
    if (hi !== 32'hCAFE_F00D || lo !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h want cafef00d", hi, lo);
    end
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'hDEAD;
    start = 1'b1;
    op = 2'd1;
    a = 32'd6;
    b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    n_chk++;
    if (hi !== 32'hCAFE_F00D || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_beats_mthi: hi=%h busy=%b want cafef00d 1",
               hi, busy);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    lo_we = 1'b1;
    wdata = 32'hBEEF;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    n_chk++;
    if (lo !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL mtlo_while_busy: lo=%h want cafef00d", lo);
    end
    exp = model(2'd1, 32'd6, 32'd7);
    wait_done(5, cyc);
    n_chk++;
    if (cyc != 34 || {hi, lo} !== exp) begin
      n_fail++;
      $display("FAIL mthi_op_result: cycle=%0d hi=%h lo=%h want 34 %h %h",
               cyc, hi, lo, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [63:0] e1, e2;
    e1 = model(2'd2, 32'hFFFF_FF00, 32'd9);
    e2 = model(2'd0, 32'h8000_0000, 32'h8000_0000);
    launch(2'd2, 32'hFFFF_FF00, 32'd9);
    wait_done(1, cyc);
    n_chk++;
    if (cyc != 34 || {hi, lo} !== e1) begin
      n_fail++;
      $display("FAIL b2b_first: cycle=%0d hi=%h lo=%h want 34 %h %h",
               cyc, hi, lo, e1[63:32], e1[31:0]);
    end
    start = 1'b1;
    op = 2'd0;
    a = 32'h8000_0000;
    b = 32'h8000_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(1, cyc);
    n_chk++;
    if (cyc != 34 || {hi, lo} !== e2) begin
      n_fail++;
      $display("FAIL b2b_second: cycle=%0d hi=%h lo=%h want 34 %h %h",
               cyc, hi, lo, e2[63:32], e2[31:0]);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_vectors;
    test_random;
    test_busy_start;
    test_midreset;
    test_mthi;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
